// File: rtl/framebuffer_scanout_if.sv
// rtl/framebuffer_scanout_if.sv - framebuffer RAM port B bus between scanout engine and RAM
interface framebuffer_scanout_if #(
  parameter int DATA = 18,
  parameter int ADDR = 14
);
  logic [ADDR-1:0] addr;
  logic [DATA-1:0] rd_data;

  modport master (output addr, input rd_data);
  modport slave (input addr, output rd_data);
endinterface

// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - VGA timing generator and scaled framebuffer fetch on RAM port B
module framebuffer_scanout #(
  parameter int DATA   = 18,
  parameter int ADDR   = 14,
  parameter int FB_W   = 128,
  parameter int FB_H   = 96,
  parameter int SCALE  = 5,
  parameter int CLKDIV = 2,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  framebuffer_scanout_if.master ram,
  output logic                  hsync,
  output logic                  vsync,
  output logic [5:0]            red,
  output logic [5:0]            green,
  output logic [5:0]            blue,
  output logic                  blank,
  output logic                  frame_start
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int DW    = $clog2(CLKDIV);

  localparam logic [HW-1:0]   H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0]   H_VISC = HW'(H_VIS);
  localparam logic [HW-1:0]   HS_BEG = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0]   HS_END = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0]   V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0]   V_VISC = VW'(V_VIS);
  localparam logic [VW-1:0]   VS_BEG = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0]   VS_END = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [SW-1:0]   S_LAST = SW'(SCALE - 1);
  localparam logic [DW-1:0]   D_LAST = DW'(CLKDIV - 1);
  localparam logic [ADDR-1:0] FB_WC  = ADDR'(FB_W);
  localparam logic [ADDR-1:0] FB_END = ADDR'(FB_W * FB_H);

  logic [DW-1:0]   div_q, div_d;
  logic [HW-1:0]   h_q, h_d, hd_q, hd_d;
  logic [VW-1:0]   v_q, v_d, vd_q, vd_d;
  logic [SW-1:0]   hsub_q, hsub_d, vsub_q, vsub_d;
  logic [ADDR-1:0] hcol_q, hcol_d, row_base_q, row_base_d, addr_q, addr_d;
  logic [DATA-1:0] rgb_q, rgb_d;
  logic            blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic            frame_start_q, frame_start_d;
  logic            tick, vis_now, vis_out;

  assign tick    = (div_q == D_LAST);
  assign vis_now = (h_q < H_VISC) && (v_q < V_VISC);
  assign vis_out = (hd_q < H_VISC) && (vd_q < V_VISC);

  always_comb begin
    div_d         = tick ? '0 : div_q + 1'b1;
    h_d           = h_q;
    v_d           = v_q;
    hd_d          = hd_q;
    vd_d          = vd_q;
    hsub_d        = hsub_q;
    vsub_d        = vsub_q;
    hcol_d        = hcol_q;
    row_base_d    = row_base_q;
    addr_d        = addr_q;
    rgb_d         = rgb_q;
    blank_d       = blank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    if (tick) begin
      // Output stage shows the previous tick's position using the word fetched for it.
      hd_d          = h_q;
      vd_d          = v_q;
      addr_d        = (vis_now && row_base_q < FB_END) ? row_base_q + hcol_q : '0;
      rgb_d         = vis_out ? ram.rd_data : '0;
      blank_d       = !vis_out;
      hsync_d       = !(hd_q >= HS_BEG && hd_q < HS_END);
      vsync_d       = !(vd_q >= VS_BEG && vd_q < VS_END);
      frame_start_d = (hd_q == '0) && (vd_q == '0);
      if (h_q == H_LAST) begin
        h_d    = '0;
        hsub_d = '0;
        hcol_d = '0;
        if (v_q == V_LAST) begin
          v_d        = '0;
          vsub_d     = '0;
          row_base_d = '0;
        end else begin
          v_d = v_q + 1'b1;
          if (v_q < V_VISC) begin
            if (vsub_q == S_LAST) begin
              vsub_d     = '0;
              row_base_d = row_base_q + FB_WC;
            end else begin
              vsub_d = vsub_q + 1'b1;
            end
          end
        end
      end else begin
        h_d = h_q + 1'b1;
        if (vis_now) begin
          if (hsub_q == S_LAST) begin
            hsub_d = '0;
            hcol_d = hcol_q + 1'b1;
          end else begin
            hsub_d = hsub_q + 1'b1;
          end
        end
      end
    end
  end

  // The pipeline position resets to the last blanked position so the first tick
  // after reset presents idle outputs and frame_start follows one tick later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hd_q          <= H_LAST;
      vd_q          <= V_LAST;
      hsub_q        <= '0;
      vsub_q        <= '0;
      hcol_q        <= '0;
      row_base_q    <= '0;
      addr_q        <= '0;
      rgb_q         <= '0;
      blank_q       <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hd_q          <= hd_d;
      vd_q          <= vd_d;
      hsub_q        <= hsub_d;
      vsub_q        <= vsub_d;
      hcol_q        <= hcol_d;
      row_base_q    <= row_base_d;
      addr_q        <= addr_d;
      rgb_q         <= rgb_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ram.addr    = addr_q;
  assign red         = rgb_q[17:12];
  assign green       = rgb_q[11:6];
  assign blue        = rgb_q[5:0];
  assign blank       = blank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - directed bench for framebuffer_scanout at full and reduced geometry
module tb_framebuffer_scanout;
  localparam int CLKDIV = 2;
  localparam int S_HT   = 56;
  localparam int S_VT   = 37;
  localparam int S_FR   = S_HT * S_VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic force_ones = 1'b1;
  logic lat_mode = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   p = -2;

  framebuffer_scanout_if #(.DATA(18), .ADDR(14)) ram_if ();
  framebuffer_scanout_if #(.DATA(18), .ADDR(14)) ram_s ();

  logic       hsync, vsync, blank, frame_start;
  logic [5:0] red, green, blue;
  logic       hsync_s, vsync_s, blank_s, frame_start_s;
  logic [5:0] red_s, green_s, blue_s;
  logic [17:0] rd_q, rd_s_q;

  framebuffer_scanout dut (
    .clk(clk), .reset(reset), .ram(ram_if),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .blank(blank), .frame_start(frame_start)
  );

  framebuffer_scanout #(
    .FB_W(8), .FB_H(6), .SCALE(5), .CLKDIV(CLKDIV),
    .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(30), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .reset(reset), .ram(ram_s),
    .hsync(hsync_s), .vsync(vsync_s), .red(red_s), .green(green_s), .blue(blue_s),
    .blank(blank_s), .frame_start(frame_start_s)
  );

  always @(posedge clk) begin
    if (lat_mode) rd_q <= (ram_if.addr == 14'd130) ? 18'h3F000 : 18'h0;
    else          rd_q <= {4'b0, ram_if.addr};
    rd_s_q <= {4'b0, ram_s.addr};
  end
  assign ram_if.rd_data = force_ones ? 18'h3FFFF : rd_q;
  assign ram_s.rd_data  = rd_s_q;

  function automatic logic [17:0] exp_word(input int h, input int v, input int w);
    return 18'((v / 5) * w + h / 5);
  endfunction

  task automatic next_out;
    repeat (CLKDIV) @(posedge clk);
    @(negedge clk);
    p++;
  endtask

  task automatic test_reset;
    int n;
    bit found;
    force_ones = 1'b1;
    lat_mode   = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    p = -2;
    repeat (150) next_out;
    total++;
    if ({blank, red} !== {1'b0, 6'd63}) begin
      bad++;
      $display("FAIL pre_reset_pixel blank/red got %b/%0d want 0/63", blank, red);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (ram_if.addr !== 14'd0) begin
      bad++; $display("FAIL reset_addr got %0d want 0", ram_if.addr);
    end
    total++;
    if ({red, green, blue} !== 18'd0) begin
      bad++; $display("FAIL reset_rgb got %h want 0", {red, green, blue});
    end
    total++;
    if (blank !== 1'b1) begin
      bad++; $display("FAIL reset_blank got %b want 1", blank);
    end
    total++;
    if ({hsync, vsync} !== 2'b11) begin
      bad++; $display("FAIL reset_sync got %b want 11", {hsync, vsync});
    end
    total++;
    if (frame_start !== 1'b0) begin
      bad++; $display("FAIL reset_frame_start got %b want 0", frame_start);
    end
    force_ones = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    found = 1'b0;
    while (n < 20 && !found) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (frame_start === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || n != 2 * CLKDIV) begin
      bad++; $display("FAIL first_frame_start clks got %0d (found=%0d) want %0d", n, found, 2 * CLKDIV);
    end
    p = 0;
  endtask

  task automatic test_horizontal;
    int h, lows;
    logic [17:0] exp_rgb;
    lows = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) next_out;
      h = p % 800;
      exp_rgb = (h < 640) ? exp_word(h, 0, 128) : 18'd0;
      if (hsync === 1'b0) lows++;
      total++;
      if (hsync !== !(h >= 656 && h < 752)) begin
        bad++; $display("FAIL hsync h=%0d got %b", h, hsync);
      end
      total++;
      if (blank !== (h >= 640)) begin
        bad++; $display("FAIL hblank h=%0d got %b", h, blank);
      end
      total++;
      if ({red, green, blue} !== exp_rgb) begin
        bad++; $display("FAIL line0_rgb h=%0d got %0d want %0d", h, {red, green, blue}, exp_rgb);
      end
      total++;
      if (frame_start !== (h == 0)) begin
        bad++; $display("FAIL line0_frame_start h=%0d got %b", h, frame_start);
      end
    end
    total++;
    if (lows != 96) begin
      bad++; $display("FAIL hsync_low_ticks got %0d want 96", lows);
    end
  endtask

  task automatic test_pixel_map;
    int h, v;
    logic [17:0] exp_rgb;
    for (int i = 800; i < 8000; i++) begin
      next_out;
      h = p % 800;
      v = p / 800;
      exp_rgb = (h < 640) ? exp_word(h, v, 128) : 18'd0;
      total++;
      if ({red, green, blue} !== exp_rgb) begin
        bad++; $display("FAIL map_rgb h=%0d v=%0d got %0d want %0d", h, v, {red, green, blue}, exp_rgb);
      end
      total++;
      if ({blank, vsync} !== {(h >= 640), 1'b1}) begin
        bad++; $display("FAIL map_blank_vsync h=%0d v=%0d got %b", h, v, {blank, vsync});
      end
      total++;
      if (ram_if.addr > 14'd12287) begin
        bad++; $display("FAIL addr_range got %0d want <=12287", ram_if.addr);
      end
    end
  endtask

  task automatic test_latency;
    int h, v, hits;
    bit hot;
    hits = 0;
    lat_mode = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    p = -2;
    next_out;
    next_out;
    for (int i = 0; i < 11 * 800; i++) begin
      if (i > 0) next_out;
      h = p % 800;
      v = p / 800;
      hot = (h >= 10 && h <= 14 && v >= 5 && v <= 9);
      if (red === 6'd63) hits++;
      total++;
      if ({red, green, blue} !== (hot ? 18'h3F000 : 18'h0)) begin
        bad++; $display("FAIL latency_rgb h=%0d v=%0d got %h want %h", h, v, {red, green, blue}, hot ? 18'h3F000 : 18'h0);
      end
    end
    total++;
    if (hits != 25) begin
      bad++; $display("FAIL latency_hits got %0d want 25", hits);
    end
    lat_mode = 1'b0;
  endtask

  task automatic test_blank_override;
    int h;
    force_ones = 1'b1;
    for (int i = 0; i < 800; i++) begin
      next_out;
      h = p % 800;
      total++;
      if ({blank, red, green, blue} !== ((h < 640) ? {1'b0, 18'h3FFFF} : {1'b1, 18'h0})) begin
        bad++; $display("FAIL override h=%0d got blank=%b rgb=%h", h, blank, {red, green, blue});
      end
    end
    force_ones = 1'b0;
  endtask

  task automatic test_vertical;
    int ps, hs, vs, vlows, starts;
    logic [17:0] exp_rgb;
    vlows = 0;
    starts = 0;
    for (int i = 0; i < 2 * S_FR; i++) begin
      next_out;
      ps = p % S_FR;
      hs = ps % S_HT;
      vs = ps / S_HT;
      exp_rgb = (hs < 40 && vs < 30) ? exp_word(hs, vs, 8) : 18'd0;
      if (vsync_s === 1'b0) vlows++;
      if (frame_start_s === 1'b1) starts++;
      total++;
      if (vsync_s !== !(vs >= 32 && vs < 34)) begin
        bad++; $display("FAIL vsync h=%0d v=%0d got %b", hs, vs, vsync_s);
      end
      total++;
      if (hsync_s !== !(hs >= 44 && hs < 52)) begin
        bad++; $display("FAIL small_hsync h=%0d v=%0d got %b", hs, vs, hsync_s);
      end
      total++;
      if (blank_s !== !(hs < 40 && vs < 30)) begin
        bad++; $display("FAIL vblank h=%0d v=%0d got %b", hs, vs, blank_s);
      end
      total++;
      if ({red_s, green_s, blue_s} !== exp_rgb) begin
        bad++; $display("FAIL small_rgb h=%0d v=%0d got %0d want %0d", hs, vs, {red_s, green_s, blue_s}, exp_rgb);
      end
      total++;
      if (frame_start_s !== (ps == 0)) begin
        bad++; $display("FAIL small_frame_start pos=%0d got %b", ps, frame_start_s);
      end
      total++;
      if (ram_s.addr > 14'd47) begin
        bad++; $display("FAIL small_addr_range got %0d want <=47", ram_s.addr);
      end
    end
    total++;
    if (vlows != 4 * S_HT) begin
      bad++; $display("FAIL vsync_low_ticks got %0d want %0d", vlows, 4 * S_HT);
    end
    total++;
    if (starts != 2) begin
      bad++; $display("FAIL frame_start_count got %0d want 2", starts);
    end
  endtask

  initial begin
    test_reset;
    test_horizontal;
    test_pixel_map;
    test_latency;
    test_blank_override;
    test_vertical;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Read-side engine for the painter's dual-port framebuffer RAM. It owns port B of the RAM: it generates 640x480@60 Hz VGA timing and fetches one 18-bit RGB 6:6:6 word per logical pixel from a 128x96 framebuffer. Each logical pixel is scaled to SCALE x SCALE screen pixels. The CPU/painter side writes port A independently; this block never writes.

## Interface
- DATA, 18: RAM word width; bits [17:12]=R, [11:6]=G, [5:0]=B
- ADDR, 14: RAM address width
- FB_W, 128: framebuffer width in words
- FB_H, 96: framebuffer height in words
- SCALE, 5: screen pixels per framebuffer pixel, both axes
- CLKDIV, 2: clk cycles per pixel tick; must be >= 2
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing in ticks
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing in lines

Ports:
- clk  in  1  system clock, same clock as RAM port B
- reset  in  1  asynchronous, active-high
- addr  out  ADDR  RAM port B address, registered
- rd_data  in  DATA  RAM port B read data; valid 1 clk after addr
- hsync  out  1  active low
- vsync  out  1  active low
- red, green, blue  out  6 each  pixel colour; 0 while blanked
- blank  out  1  high outside the visible region
- frame_start  out  1  one-clk pulse at start of each frame

## Operation
- **Tick divider:** counts 0..CLKDIV-1. A tick is asserted for one clk when the divider count is CLKDIV-1. All state below advances only on a tick.
- **Counters:**
  - h: 0..799. At 799 it wraps to 0 and v increments.
  - v: 0..524. At 524 it wraps to 0.
  - Visible region: h<640 and v<480.
- **Scaling sub-counters** (no divider or multiplier):
  - hsub 0..SCALE-1: increments each visible tick; on wrap, hcol increments.
  - hcol, hsub: reset to 0 at h wrap.
  - vsub 0..SCALE-1: increments at end of each visible line; on wrap, vrow increments and row_base += FB_W.
  - vrow, vsub, row_base: reset to 0 when v wraps.
- **Address:**
  - On each tick, addr <= row_base + hcol if the current (h,v) is visible, else 0.
  - addr is always within 0..FB_W*FB_H-1. Max is 12287 at (639,479).
- **Output stage:** on each tick, capture the pipeline values:
  - {red,green,blue} <= rd_data fields if the delayed visible flag is set, else 0.
  - blank <= !visible(h_d,v_d).
  - hsync <= !(656 <= h_d < 752).
  - vsync <= !(490 <= v_d < 492).
  - Here (h_d,v_d) is the counter position from the previous tick.
- **frame_start:** high for exactly one clk, on the tick whose output stage presents (h_d,v_d)=(0,0).
- **Reset values:**
  - addr=0, red=green=blue=0, blank=1, hsync=1, vsync=1, frame_start=0.
  - All counters, row_base and the divider = 0.

## Timing
- RAM latency is 1 clk. CLKDIV>=2 guarantees rd_data is stable before the next tick captures it. addr is held constant between ticks.
- Latency from counter position to outputs: exactly 1 tick (CLKDIV clks). Sync, blank and colour are aligned to the same pixel.
- Line period is 800 ticks; frame period is 800*525 ticks.
- hsync is low for 96 consecutive ticks per line. vsync is low for 2 lines per frame.
- **Boundaries:**
  - Last visible pixel (639,479) reads addr 12287.
  - Pixel (640,y) shows blank=1 with RGB=0, regardless of rd_data.
  - Wrap (799,524)->(0,0) restarts row_base=0 on the same tick.
- **Reset asserted mid-frame:**
  - All outputs take their reset values immediately, without waiting for clk.
  - After release, the first tick occurs CLKDIV clks later and scanning starts at (0,0).
  - frame_start pulses on the following tick.

## Test plan
- **Reset:** assert reset mid-line with rd_data=18'h3FFFF -> addr=0, RGB=0, blank=1, hsync=vsync=1, frame_start=0. After release, first frame_start exactly 2*CLKDIV clks later.
- **Horizontal timing:** run one line -> hsync low from output tick 656 to 751 (96 ticks), period 800 ticks (1600 clks at CLKDIV=2). blank high for output ticks 640..799.
- **Vertical timing:** run one full frame -> vsync low for lines 490-491 only. frame_start period 420000 ticks.
- **Pixel mapping:** preload a RAM model with mem[a]=a.
  - Screen (0..4,0..4) shows word 0.
  - (5,0) shows 1.
  - (0,5) shows 128.
  - (639,479) shows 12287, i.e. R=2, G=63, B=63.
  - addr never exceeds 12287.
- **Blanking override:** force rd_data=18'h3FFFF throughout -> RGB=0 at every tick where blank=1, and RGB=63/63/63 at every visible tick.
- **Latency:** with a single word set at mem[130]=18'h3F000 and zeros elsewhere -> red=63 only at screen h 10..14, v 5..9. The change appears exactly 1 tick after the counter reaches that position.
